// File: rtl/regfile_mp.sv
// Parametrised register file: NRD registered read ports, two byte-enabled write
// ports (port 1 wins per byte), per-byte write-through bypass, optional zero register.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int NB = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [NB-1:0]         wbe0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NB-1:0]         wbe1,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic                  wr_collision
);

  // Every address value gets a slot in mem_next; slots past DEPTH read as zero,
  // so out-of-range reads need no separate range check.
  localparam int NSLOT = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem_reg  [DEPTH];
  logic [DATA_W-1:0]     mem_next [NSLOT];
  logic [NB-1:0]         coll_byte;
  logic                  wr_collision_next;
  logic                  wr_collision_reg;
  logic [NRD*DATA_W-1:0] rdata_next;
  logic [NRD*DATA_W-1:0] rdata_reg;

  function automatic logic writable(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  genvar gi, gj;

  // Post-write image of each register; also the source of the read bypass.
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < DEPTH) begin : g_live
        localparam logic [AW-1:0] ADDR   = AW'(gi);
        localparam bit            LOCKED = (ZERO_REG != 0) && (gi == 0);
        for (gj = 0; gj < NB; gj++) begin : g_byte
          logic hit0, hit1;
          assign hit0 = !LOCKED && we0 && wbe0[gj] && (waddr0 == ADDR);
          assign hit1 = !LOCKED && we1 && wbe1[gj] && (waddr1 == ADDR);
          assign mem_next[gi][gj*8 +: 8] = hit1 ? wdata1[gj*8 +: 8] :
                                           hit0 ? wdata0[gj*8 +: 8] :
                                                  mem_reg[gi][gj*8 +: 8];
        end
      end else begin : g_dead
        assign mem_next[gi] = '0;
      end
    end

    for (gj = 0; gj < NB; gj++) begin : g_coll
      assign coll_byte[gj] = we0 && we1 && wbe0[gj] && wbe1[gj];
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = raddr[gi*AW +: AW];
      assign rdata_next[gi*DATA_W +: DATA_W] =
          ((ZERO_REG != 0) && (ra == '0)) ? '0 : mem_next[ra];
    end
  endgenerate

  assign wr_collision_next = (|coll_byte) && (waddr0 == waddr1) && writable(waddr0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      rdata_reg        <= '0;
      wr_collision_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
      rdata_reg        <= rdata_next;
      wr_collision_reg <= wr_collision_next;
    end
  end

  assign rdata        = rdata_reg;
  assign wr_collision = wr_collision_reg;

endmodule
